// File: rtl/clk_lock_supervisor.sv
// Lock supervisor for a clocking wizard: drives the wizard reset, qualifies lock
// over a stability window and re-resets the wizard on timeout, lock loss or input stop.
module clk_lock_supervisor #(
  parameter int SYNC_STAGES  = 2,
  parameter int RESET_CYCLES = 200,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int LOCK_STABLE  = 64
) (
  input  logic       clk_in1,
  input  logic       reset,
  input  logic       locked,
  input  logic       input_clk_stopped,
  output logic       mmcm_reset,
  output logic       rst_out,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] retry_count,
  output logic [1:0] state
);

  localparam int MAX_A = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_V = (MAX_A > LOCK_STABLE) ? MAX_A : LOCK_STABLE;
  localparam int TW    = $clog2(MAX_V + 1);

  localparam logic [TW-1:0] RST_LAST = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STB_LAST = TW'(LOCK_STABLE - 1);

  typedef enum logic [1:0] {
    S_RESET     = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [TW-1:0]          r_timer;
  logic [TW-1:0]          w_timer_next;
  logic [SYNC_STAGES-1:0] r_lk_sync;
  logic [SYNC_STAGES-1:0] r_stp_sync;
  logic                   w_lk_s;
  logic                   w_stp_s;
  logic                   w_retry;
  logic                   r_mmcm_reset;
  logic                   r_rst_out;
  logic                   r_ready;
  logic                   r_lock_lost;
  logic [7:0]             r_retry_count;

  assign w_lk_s  = r_lk_sync[SYNC_STAGES-1];
  assign w_stp_s = r_stp_sync[SYNC_STAGES-1];

  always_comb begin
    w_next       = r_state;
    w_timer_next = r_timer + 1'b1;
    case (r_state)
      S_RESET: begin
        // A stopped input clock keeps the wizard in reset for a full window after it resumes
        if (w_stp_s)                   w_timer_next = '0;
        else if (r_timer == RST_LAST)  w_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (w_stp_s)                   w_next = S_RESET;
        else if (w_lk_s)               w_next = S_STABLE;
        else if (r_timer == TO_LAST)   w_next = S_RESET;
      end
      S_STABLE: begin
        if (w_stp_s)                   w_next = S_RESET;
        else if (!w_lk_s)              w_next = S_WAIT_LOCK;
        else if (r_timer == STB_LAST)  w_next = S_RUN;
      end
      S_RUN: begin
        w_timer_next = '0;
        if (!w_lk_s || w_stp_s)        w_next = S_RESET;
      end
      default: w_next = S_RESET;
    endcase
    if (w_next != r_state) w_timer_next = '0;
  end

  // Every entry into RESET from another state is a wizard re-reset
  assign w_retry = (w_next == S_RESET) && (r_state != S_RESET);

  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      r_state       <= S_RESET;
      r_timer       <= '0;
      r_lk_sync     <= '0;
      r_stp_sync    <= '0;
      r_mmcm_reset  <= 1'b1;
      r_rst_out     <= 1'b1;
      r_ready       <= 1'b0;
      r_lock_lost   <= 1'b0;
      r_retry_count <= 8'd0;
    end else begin
      r_state       <= w_next;
      r_timer       <= w_timer_next;
      r_lk_sync     <= {r_lk_sync[SYNC_STAGES-2:0], locked};
      r_stp_sync    <= {r_stp_sync[SYNC_STAGES-2:0], input_clk_stopped};
      r_mmcm_reset  <= (w_next == S_RESET);
      r_rst_out     <= (w_next != S_RUN);
      r_ready       <= (w_next == S_RUN);
      r_lock_lost   <= (r_state == S_RUN) && (w_next == S_RESET);
      if (w_retry && (r_retry_count != 8'hFF))
        r_retry_count <= r_retry_count + 8'd1;
    end
  end

  assign mmcm_reset  = r_mmcm_reset;
  assign rst_out     = r_rst_out;
  assign ready       = r_ready;
  assign lock_lost   = r_lock_lost;
  assign retry_count = r_retry_count;
  assign state       = r_state;

endmodule
